// File: rtl/ff_delay_line.sv
// Stallable WIDTH x DEPTH delay line with per-stage valid,
// tap select, flush and registered occupancy count.
module ff_delay_line #(
   parameter int unsigned           WIDTH     = 8,
   parameter int unsigned           DEPTH     = 4,
   parameter logic [WIDTH-1:0]      RESET_VAL = '0,
   localparam int unsigned          TW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned          FW = $clog2(DEPTH + 1)
) (
   input  logic             CK,
   input  logic             SR,
   input  logic             CE,
   input  logic             FLUSH,
   input  logic [WIDTH-1:0] D,
   input  logic             DV,
   input  logic [TW-1:0]    TAP_SEL,
   output logic [WIDTH-1:0] Q,
   output logic             QV,
   output logic [WIDTH-1:0] TAP_Q,
   output logic             TAP_V,
   output logic [FW-1:0]    FILL
);

   logic [WIDTH-1:0] data_q [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];
   logic [DEPTH-1:0] vld_q;
   logic [DEPTH-1:0] vld_d;
   logic [FW-1:0]    fill_q;
   logic [FW-1:0]    fill_d;

   always_comb begin
      data_d = data_q;
      vld_d  = vld_q;
      if (CE) begin
         data_d[0] = D;
         vld_d[0]  = DV;
         for (int i = 1; i < int'(DEPTH); i++) begin
            data_d[i] = data_q[i-1];
            vld_d[i]  = vld_q[i-1];
         end
      end
      if (FLUSH) begin
         vld_d = '0;
      end
   end

   // Count the next-state valids so FILL lines up with the visible bits.
   always_comb begin
      fill_d = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         fill_d = fill_d + FW'(vld_d[i]);
      end
   end

   always_ff @(posedge CK) begin
      if (!SR) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            data_q[i] <= RESET_VAL;
         end
         vld_q  <= '0;
         fill_q <= '0;
      end else begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            data_q[i] <= data_d[i];
         end
         vld_q  <= vld_d;
         fill_q <= fill_d;
      end
   end

   // Out-of-range selects fall through to the reset pattern.
   always_comb begin
      TAP_Q = RESET_VAL;
      TAP_V = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (int'(TAP_SEL) == i) begin
            TAP_Q = data_q[i];
            TAP_V = vld_q[i];
         end
      end
   end

   assign Q    = data_q[DEPTH-1];
   assign QV   = vld_q[DEPTH-1];
   assign FILL = fill_q;

endmodule

// File: tb/tb_ff_delay_line.sv
// Directed vector bench for ff_delay_line: main DEPTH=4 instance
// plus DEPTH=1 and DEPTH=5 corner instances on shared inputs.
module tb_ff_delay_line;

   typedef struct {
      logic       sr;
      logic       ce;
      logic       fl;
      logic [7:0] d;
      logic       dv;
      logic [1:0] tap;
      logic [7:0] q;
      logic       qv;
      logic [2:0] fill;
      logic [7:0] tq;
      logic       tv;
   } vec_t;

   logic       CK = 1'b0;
   logic       SR = 1'b0;
   logic       CE = 1'b0;
   logic       FLUSH = 1'b0;
   logic [7:0] D = '0;
   logic       DV = 1'b0;

   logic [1:0] tap4 = '0;
   logic [7:0] q4, tq4;
   logic       qv4, tv4;
   logic [2:0] fill4;

   logic       tap1 = 1'b0;
   logic [7:0] q1, tq1;
   logic       qv1, tv1;
   logic       fill1;

   logic [2:0] tap5 = 3'd6;
   logic [7:0] q5, tq5;
   logic       qv5, tv5;
   logic [2:0] fill5;

   int checks = 0;
   int errors = 0;

   always #5 CK = ~CK;

   ff_delay_line #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5)) u_d4 (
      .CK(CK), .SR(SR), .CE(CE), .FLUSH(FLUSH), .D(D), .DV(DV),
      .TAP_SEL(tap4), .Q(q4), .QV(qv4), .TAP_Q(tq4), .TAP_V(tv4),
      .FILL(fill4)
   );

   ff_delay_line #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) u_d1 (
      .CK(CK), .SR(SR), .CE(CE), .FLUSH(FLUSH), .D(D), .DV(DV),
      .TAP_SEL(tap1), .Q(q1), .QV(qv1), .TAP_Q(tq1), .TAP_V(tv1),
      .FILL(fill1)
   );

   ff_delay_line #(.WIDTH(8), .DEPTH(5), .RESET_VAL(8'h3C)) u_d5 (
      .CK(CK), .SR(SR), .CE(CE), .FLUSH(FLUSH), .D(D), .DV(DV),
      .TAP_SEL(tap5), .Q(q5), .QV(qv5), .TAP_Q(tq5), .TAP_V(tv5),
      .FILL(fill5)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic sr, input logic ce, input logic fl,
      input logic [7:0] d, input logic dv, input logic [1:0] tap,
      input logic [7:0] q, input logic qv, input logic [2:0] fill,
      input logic [7:0] tq, input logic tv);
      vec_t v;
      v.sr = sr; v.ce = ce; v.fl = fl; v.d = d; v.dv = dv;
      v.tap = tap; v.q = q; v.qv = qv; v.fill = fill;
      v.tq = tq; v.tv = tv;
      return v;
   endfunction

   task automatic step(input logic sr, input logic ce, input logic fl,
                       input logic [7:0] d, input logic dv);
      SR = sr; CE = ce; FLUSH = fl; D = d; DV = dv;
      @(posedge CK);
      #1;
   endtask

   vec_t vecs[$];

   initial begin
      // sr ce fl d dv tap | q qv fill tq tv
      // reset with CE/D/DV active
      vecs.push_back(mk(0,1,0,8'hFF,1,0, 8'hA5,0,0, 8'hA5,0));
      vecs.push_back(mk(0,1,0,8'hFF,1,1, 8'hA5,0,0, 8'hA5,0));
      // streaming 1..5 then drain
      vecs.push_back(mk(1,1,0,8'd1,1,1, 8'hA5,0,1, 8'hA5,0));
      vecs.push_back(mk(1,1,0,8'd2,1,1, 8'hA5,0,2, 8'd1,1));
      vecs.push_back(mk(1,1,0,8'd3,1,2, 8'hA5,0,3, 8'd1,1));
      vecs.push_back(mk(1,1,0,8'd4,1,3, 8'd1,1,4, 8'd1,1));
      vecs.push_back(mk(1,1,0,8'd5,1,0, 8'd2,1,4, 8'd5,1));
      vecs.push_back(mk(1,1,0,8'd0,0,0, 8'd3,1,3, 8'd0,0));
      vecs.push_back(mk(1,1,0,8'd0,0,1, 8'd4,1,2, 8'd0,0));
      vecs.push_back(mk(1,1,0,8'd0,0,3, 8'd5,1,1, 8'd5,1));
      vecs.push_back(mk(1,1,0,8'd0,0,2, 8'd0,0,0, 8'd0,0));
      // stall after D=2
      vecs.push_back(mk(0,1,0,8'd0,0,0, 8'hA5,0,0, 8'hA5,0));
      vecs.push_back(mk(1,1,0,8'd1,1,0, 8'hA5,0,1, 8'd1,1));
      vecs.push_back(mk(1,1,0,8'd2,1,1, 8'hA5,0,2, 8'd1,1));
      vecs.push_back(mk(1,0,0,8'd99,1,0, 8'hA5,0,2, 8'd2,1));
      vecs.push_back(mk(1,0,0,8'd99,1,1, 8'hA5,0,2, 8'd1,1));
      vecs.push_back(mk(1,0,0,8'd99,1,2, 8'hA5,0,2, 8'hA5,0));
      vecs.push_back(mk(1,1,0,8'd3,1,2, 8'hA5,0,3, 8'd1,1));
      vecs.push_back(mk(1,1,0,8'd4,1,0, 8'd1,1,4, 8'd4,1));
      vecs.push_back(mk(1,1,0,8'd5,1,3, 8'd2,1,4, 8'd2,1));
      // fill with 10..13 (stage0=10 .. stage3=13)
      vecs.push_back(mk(1,1,0,8'd13,1,0, 8'd3,1,4, 8'd13,1));
      vecs.push_back(mk(1,1,0,8'd12,1,0, 8'd4,1,4, 8'd12,1));
      vecs.push_back(mk(1,1,0,8'd11,1,0, 8'd5,1,4, 8'd11,1));
      vecs.push_back(mk(1,1,0,8'd10,1,0, 8'd13,1,4, 8'd10,1));
      // flush with CE=1, data still shifts
      vecs.push_back(mk(1,1,1,8'd20,1,0, 8'd12,0,0, 8'd20,0));
      vecs.push_back(mk(1,0,0,8'd77,1,1, 8'd12,0,0, 8'd10,0));
      vecs.push_back(mk(1,0,0,8'd77,1,2, 8'd12,0,0, 8'd11,0));
      vecs.push_back(mk(1,0,0,8'd77,1,3, 8'd12,0,0, 8'd12,0));
      vecs.push_back(mk(1,1,0,8'd21,1,0, 8'd11,0,1, 8'd21,1));
      // three in flight, then reset together with flush
      vecs.push_back(mk(1,1,0,8'd22,1,1, 8'd10,0,2, 8'd21,1));
      vecs.push_back(mk(1,1,0,8'd23,1,2, 8'd20,0,3, 8'd21,1));
      vecs.push_back(mk(0,1,1,8'd99,1,1, 8'hA5,0,0, 8'hA5,0));
      vecs.push_back(mk(1,1,0,8'd50,1,0, 8'hA5,0,1, 8'd50,1));
      vecs.push_back(mk(1,1,0,8'd51,1,1, 8'hA5,0,2, 8'd50,1));
      vecs.push_back(mk(1,1,0,8'd52,1,2, 8'hA5,0,3, 8'd50,1));
      vecs.push_back(mk(1,1,0,8'd53,1,3, 8'd50,1,4, 8'd50,1));
      // flush while stalled: data holds, valids clear
      vecs.push_back(mk(1,0,1,8'd99,1,0, 8'd50,0,0, 8'd53,0));

      repeat (2) @(negedge CK);

      for (int i = 0; i < vecs.size(); i++) begin
         tap4 = vecs[i].tap;
         step(vecs[i].sr, vecs[i].ce, vecs[i].fl, vecs[i].d, vecs[i].dv);
         chk($sformatf("v%0d Q", i), 32'(q4), 32'(vecs[i].q));
         chk($sformatf("v%0d QV", i), 32'(qv4), 32'(vecs[i].qv));
         chk($sformatf("v%0d FILL", i), 32'(fill4), 32'(vecs[i].fill));
         chk($sformatf("v%0d TAP_Q", i), 32'(tq4), 32'(vecs[i].tq));
         chk($sformatf("v%0d TAP_V", i), 32'(tv4), 32'(vecs[i].tv));

         // every tap reads the reset pattern right after reset
         if (i == 1) begin
            for (int t = 0; t < 4; t++) begin
               tap4 = 2'(t);
               #1;
               chk($sformatf("rst tap%0d Q", t), 32'(tq4), 32'hA5);
               chk($sformatf("rst tap%0d V", t), 32'(tv4), 32'h0);
            end
         end
      end

      // DEPTH=1 and DEPTH=5 corners
      step(0, 1, 0, 8'h00, 0);
      chk("d5 rst Q", 32'(q5), 32'h3C);
      chk("d5 rst FILL", 32'(fill5), 32'h0);
      chk("d1 rst FILL", 32'(fill1), 32'h0);
      for (int k = 0; k < 5; k++) begin
         step(1, 1, 0, 8'(8'h60 + k), 1);
         chk($sformatf("d1 Q k%0d", k), 32'(q1), 32'h60 + 32'(k));
         chk($sformatf("d1 QV k%0d", k), 32'(qv1), 32'h1);
         chk($sformatf("d5 FILL k%0d", k), 32'(fill5), 32'(k + 1));
         chk($sformatf("d5 QV k%0d", k), 32'(qv5), (k == 4) ? 32'h1 : 32'h0);
      end
      chk("d1 FILL", 32'(fill1), 32'h1);
      chk("d1 TAP_Q", 32'(tq1), 32'h64);
      chk("d5 Q", 32'(q5), 32'h60);
      chk("d5 tap6 Q", 32'(tq5), 32'h3C);
      chk("d5 tap6 V", 32'(tv5), 32'h0);
      tap5 = 3'd4;
      #1;
      chk("d5 tap4 Q", 32'(tq5), 32'h60);
      chk("d5 tap4 V", 32'(tv5), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/ff_delay_line.md
# ff_delay_line

Parametrised, clock-enabled delay line. It generalises the single enable flip-flop to WIDTH bits × DEPTH stages, with per-stage valid tracking, a selectable tap, a flush control and a registered occupancy count. It sits wherever a data path needs a fixed, stallable latency, such as aligning data with a pipelined control path, and is the standard register primitive for later chapters.

## Interface
- WIDTH, 8, data width in bits; must be ≥ 1.
- DEPTH, 4, number of stages; must be ≥ 1.
- RESET_VAL, '0, WIDTH-bit value loaded into every data stage on reset.
- CK  in  1  clock; all state updates on rising edge.
- SR  in  1  reset, synchronous, active-low; sampled on the CK rising edge.
- CE  in  1  clock enable; the line shifts only when CE=1.
- FLUSH  in  1  synchronous clear of all valid bits; data stages are not cleared.
- D  in  WIDTH  input data.
- DV  in  1  input valid, shifted alongside D.
- TAP_SEL  in  $clog2(DEPTH)>0 ? $clog2(DEPTH) : 1  stage index for the tap outputs.
- Q  out  WIDTH  stage DEPTH-1 data.
- QV  out  1  stage DEPTH-1 valid.
- TAP_Q  out  WIDTH  data of stage TAP_SEL.
- TAP_V  out  1  valid of stage TAP_SEL.
- FILL  out  $clog2(DEPTH+1)  count of stages holding valid=1.

## Operation
- State: data[0..DEPTH-1] (WIDTH each), vld[0..DEPTH-1], fill register.
- Priority per edge: SR=0 > FLUSH=1 > CE.
- SR=0: all data[i] ← RESET_VAL, all vld[i] ← 0, fill ← 0, regardless of CE, FLUSH, D and DV.
- SR=1, CE=1: data[0] ← D, data[i] ← data[i-1]; vld shifts the same way, with vld[0] ← DV.
- SR=1, CE=0: all state holds. D and DV are ignored.
- FLUSH=1 (with SR=1): all vld[i] ← 0 and fill ← 0. Data shifts if CE=1 and holds if CE=0. DV on the same cycle is discarded.
- fill is registered. It equals the popcount of the next-state vld vector, so FILL always matches the vld bits currently visible.
- Q = data[DEPTH-1] and QV = vld[DEPTH-1], driven directly from the registers.
- TAP_Q / TAP_V form a combinational mux over stages by TAP_SEL.
- TAP_SEL ≥ DEPTH (possible when DEPTH is not a power of two): TAP_Q = RESET_VAL, TAP_V = 0.
- DEPTH=1: TAP_SEL is 1 bit and only value 0 is legal. FILL is 1 bit.
- Data is passed through unmodified. No arithmetic is performed except the popcount, which saturates naturally at DEPTH.

## Timing
- Reset values: Q = RESET_VAL, QV = 0, FILL = 0. TAP_Q = RESET_VAL and TAP_V = 0 for every TAP_SEL.
- Reset takes effect on the first CK edge with SR=0. Outputs show the reset values after that edge.
- Latency D→Q is DEPTH CE-qualified edges. With CE held high, D sampled at edge n appears on Q after edge n+DEPTH-1.
- Tap latency is TAP_SEL+1 CE-qualified edges.
- CE low cycles stretch latency one-for-one. No sample is lost or duplicated.
- Reset asserted mid-stream discards all in-flight data. The first sample accepted after SR returns high has full DEPTH latency.
- SR and FLUSH asserted together: the reset behaviour applies, and data returns to RESET_VAL.
- TAP outputs change combinationally with TAP_SEL within the same cycle. No other output depends combinationally on any input.

## Test plan
- Reset: WIDTH=8, DEPTH=4, RESET_VAL=8'hA5. Hold SR=0 for 2 edges with CE=1, D=8'hFF, DV=1. Required: Q=8'hA5, QV=0, FILL=0, TAP_Q=8'hA5 for TAP_SEL 0..3.
- Streaming: SR=1, CE=1, DV=1. Drive D=1,2,3,4,5 on consecutive edges. Required:
  - FILL counts 1,2,3,4,4.
  - Q=1 with QV=1 after the 4th edge; Q=5 after the 8th edge.
  - TAP_SEL=1 shows D=1 after edge 2.
- Stall: as streaming, but CE=0 for 3 cycles after D=2 is accepted. Required: all outputs frozen during the stall, D ignored, and Q=1 appears 3 cycles later than in the stall-free run.
- Flush: line full of valid 10,11,12,13. Assert FLUSH=1 with CE=1, D=20, DV=1 for one edge. Required:
  - QV=0, FILL=0, all TAP_V=0.
  - Data shifted: TAP_SEL=0 shows 20 and Q=12.
  - Next edge with DV=1 gives FILL=1.
- Mid-stream reset: 3 valid samples in flight, then SR=0 for one edge together with FLUSH=1. Required: all stages RESET_VAL, FILL=0, and the next accepted sample appears on Q after exactly 4 CE edges.
- Parameter corners: DEPTH=1 gives Q 1 edge after D. DEPTH=5 with TAP_SEL=6 gives TAP_Q=RESET_VAL and TAP_V=0, while FILL reaches 5 when full.
